// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding request to instruction memory, a single-word
// skid buffer for a stalled decode stage, and branch redirection with squash of in-flight data.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        branch_en,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic [31:0] dirs,
  output logic [31:0] pc_out,
  output logic        valid
);

  typedef enum logic [1:0] {StReq, StHold, StSquash} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] dirs_q, dirs_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;

  logic        ack;
  logic [31:0] br_tgt;
  logic [31:0] pc_inc;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack    = imem_ack && imem_req;
  assign br_tgt = {branch_target[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReq: begin
        if (branch_en) begin
          state_d = ack ? StReq : StSquash;
        end else if (ack && valid_q && stall) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (branch_en || !stall) begin
          state_d = StReq;
        end
      end
      StSquash: begin
        if (ack) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      imem_req = (state_q != StHold);
    end
  end

  assign imem_addr = pc_q;
  assign dirs      = dirs_q;
  assign pc_out    = pc_out_q;
  assign valid     = valid_q;

  // Datapath next values
  always_comb begin
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    dirs_d     = dirs_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    unique case (state_q)
      StReq: begin
        if (branch_en) begin
          valid_d = 1'b0;
          if (ack) begin
            pc_d = br_tgt;
          end else begin
            tgt_d = br_tgt;
          end
        end else if (ack) begin
          pc_d = pc_inc;
          if (!valid_q || !stall) begin
            dirs_d   = imem_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end else begin
            buf_data_d = imem_data;
            buf_pc_d   = pc_q;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StHold: begin
        if (branch_en) begin
          valid_d = 1'b0;
          pc_d    = br_tgt;
        end else if (!stall) begin
          dirs_d   = buf_data_q;
          pc_out_d = buf_pc_q;
          valid_d  = 1'b1;
        end
      end
      StSquash: begin
        // Old address stays on the bus until the in-flight word returns and is dropped.
        if (branch_en) begin
          valid_d = 1'b0;
          tgt_d   = br_tgt;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
        if (ack) begin
          pc_d = branch_en ? br_tgt : tgt_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tgt_q      <= RESET_PC;
      buf_data_q <= 32'd0;
      buf_pc_q   <= 32'd0;
      dirs_q     <= 32'd0;
      pc_out_q   <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
      dirs_q     <= dirs_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by randomized traffic,
// all compared against a transaction-level reference model.
module tb_instr_fetch;

  localparam logic [31:0] RstPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] dirs;
  logic [31:0] pc_out;
  logic        valid;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch #(.RESET_PC(RstPc)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .stall         (stall),
    .dirs          (dirs),
    .pc_out        (pc_out),
    .valid         (valid)
  );

  always #5 clk = ~clk;

  // Reference model: fetch address, optional pending redirect, and a queue of words
  // fetched but not yet accepted downstream (at most one).
  logic [31:0] m_pc, m_redirect, m_dirs, m_pcout;
  logic        m_valid, m_discard;
  logic [63:0] m_parked[$];

  function automatic logic m_req();
    return !rst && (m_parked.size() == 0);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        got;
    logic [31:0] tgt;
    got = imem_ack && m_req();
    tgt = branch_target & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = RstPc; m_dirs = '0; m_pcout = '0; m_valid = 1'b0;
      m_discard = 1'b0; m_parked.delete();
    end else if (m_parked.size() != 0) begin
      if (branch_en) begin
        m_parked.delete(); m_valid = 1'b0; m_pc = tgt;
      end else if (!stall) begin
        {m_pcout, m_dirs} = m_parked.pop_front(); m_valid = 1'b1;
      end
    end else if (m_discard) begin
      if (branch_en) m_redirect = tgt;
      if (branch_en || !stall) m_valid = 1'b0;
      if (got) begin
        m_discard = 1'b0; m_pc = m_redirect;
      end
    end else if (branch_en) begin
      m_valid = 1'b0;
      if (got) m_pc = tgt;
      else begin
        m_discard = 1'b1; m_redirect = tgt;
      end
    end else if (got) begin
      if (m_valid && stall) m_parked.push_back({m_pc, imem_data});
      else begin
        m_dirs = imem_data; m_pcout = m_pc; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, check the request side, clock, then check the registers.
  task automatic cyc(input logic r, input logic a, input logic [31:0] d, input logic b,
                     input logic [31:0] t, input logic s);
    rst = r; imem_ack = a; imem_data = d; branch_en = b; branch_target = t; stall = s;
    #1;
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
    if (m_req()) check_eq("imem_addr", imem_addr, m_pc);
    @(posedge clk);
    model_step();
    #1;
    check_eq("dirs", dirs, m_dirs);
    check_eq("pc_out", pc_out, m_pcout);
    check_eq("valid", {31'd0, valid}, {31'd0, m_valid});
  endtask

  initial begin
    m_pc = RstPc; m_redirect = RstPc; m_dirs = '0; m_pcout = '0;
    m_valid = 1'b0; m_discard = 1'b0;
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; branch_en = 1'b0;
    branch_target = '0; stall = 1'b0;
    @(negedge clk);

    // Reset
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h1111_1111, 0, 0, 0);
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_valid", {31'd0, valid}, 32'd0);

    // Zero-wait fetch of two words
    cyc(0, 1, 32'h0234_701A, 0, 0, 0);
    check_eq("w0_dirs", dirs, 32'h0234_701A);
    check_eq("w0_pc", pc_out, 32'h0);
    check_eq("w0_valid", {31'd0, valid}, 32'd1);
    cyc(0, 1, 32'h02CD_6022, 0, 0, 0);
    check_eq("w1_dirs", dirs, 32'h02CD_6022);
    check_eq("w1_pc", pc_out, 32'h4);

    // Stall with ack for 0x8 parks the word
    cyc(0, 1, 32'hAAAA_0008, 0, 0, 1);
    #1;
    check_eq("hold_req", {31'd0, imem_req}, 32'd0);
    check_eq("hold_pc", pc_out, 32'h4);
    cyc(0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    check_eq("unhold_pc", pc_out, 32'h8);
    check_eq("unhold_addr", imem_addr, 32'hC);

    // Branch while waiting; late word is squashed
    cyc(0, 0, 0, 1, 32'h40, 0);
    check_eq("sq_addr_old", imem_addr, 32'hC);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check_eq("sq_valid", {31'd0, valid}, 32'd0);
    check_eq("sq_addr_new", imem_addr, 32'h40);

    // Misaligned target, ack+branch same cycle, and PC wrap
    cyc(0, 1, 32'h1234_5678, 1, 32'h43, 0);
    check_eq("align_addr", imem_addr, 32'h40);
    check_eq("ackbr_valid", {31'd0, valid}, 32'd0);
    cyc(0, 1, 32'h5555_5555, 1, 32'hFFFF_FFFC, 0);
    cyc(0, 1, 32'h7777_7777, 0, 0, 0);
    check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset mid-wait with a late ack
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 1, 32'h9999_9999, 0, 0, 0);
    check_eq("mrst_dirs", dirs, 32'd0);
    rst = 1'b0; imem_ack = 1'b0; #1;
    check_eq("mrst_req", {31'd0, imem_req}, 32'd1);
    check_eq("mrst_addr", imem_addr, RstPc);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), $urandom,
          ($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 9) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
